// File: rtl/regbus_defs.sv
`default_nettype none
// ============================================================================
//  Module   : regbus_defs (package)
//  Brief    : Shared state encoding and sizing helpers for the register-bus
//             read/write controller.
//  Revision : 1.0 - initial release
// ============================================================================
package regbus_defs;

    // Controller states; the encoding is shared so all users agree on it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        SEL  = 2'd2,
        RSP  = 2'd3
    } state_t;

    // Settle-counter width. The extra bit keeps SettleCycles itself
    // representable, even when it is a power of two.
    function automatic int cnt_width(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regbus_decode.sv
`default_nettype none
// ============================================================================
//  Module   : regbus_decode
//  Brief    : Address to one-hot decoder with enable. Flags addresses that
//             fall beyond the populated register count.
//  Revision : 1.0 - initial release
// ============================================================================
module regbus_decode #(
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3
) (
    input  logic [AddrBits-1:0] addr,
    input  logic                en,
    output logic [NrOfRegs-1:0] onehot,
    output logic                out_of_range
);

    // Widened by one bit so that NrOfRegs == 2**AddrBits still fits.
    localparam logic [AddrBits:0] c_nregs = (AddrBits+1)'(NrOfRegs);

    // The range flag is independent of the enable, so it is usable during accept.
    assign out_of_range = {1'b0, addr} >= c_nregs;

    // One comparator per populated register, all gated by the enable.
    for (genvar i = 0; i < NrOfRegs; i++) begin : g_sel
        assign onehot[i] = en && ({1'b0, addr} == (AddrBits+1)'(i));
    end

endmodule
`default_nettype wire

// File: rtl/regbus_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regbus_read_ctrl
//  Brief    : Bus master for a bank of tri-state registers. Serves one
//             read or write request at a time. Writes pulse a one-hot
//             ClockEnable. Reads assert a chip-select, wait out the settle
//             time, then sample the shared bus.
//  Revision : 1.0 - initial release
// ============================================================================
module regbus_read_ctrl
    import regbus_defs::*;
#(
    parameter int NrOfBits     = 32,
    parameter int NrOfRegs     = 8,
    parameter int AddrBits     = 3,
    parameter int SettleCycles = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Tick,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AddrBits-1:0] req_addr,
    input  logic [NrOfBits-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [NrOfBits-1:0] rsp_data,
    output logic                rsp_err,
    output logic [NrOfRegs-1:0] cs,
    output logic [NrOfRegs-1:0] we,
    output logic [NrOfBits-1:0] wr_data,
    input  logic [NrOfBits-1:0] bus
);

    localparam int                 c_cnt_w    = cnt_width(SettleCycles);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(SettleCycles - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AddrBits-1:0]   r_addr;
    logic [NrOfBits-1:0]   r_wdata;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [NrOfBits-1:0]   r_rsp_data;
    logic                  r_rsp_err;
    logic [AddrBits-1:0]   w_dec_addr;
    logic                  w_dec_en;
    logic [NrOfRegs-1:0]   w_onehot;
    logic                  w_oor;

    // In IDLE, decode the incoming address so a bad address is rejected at accept.
    // In other states, decode the latched address.
    assign w_dec_addr = (r_state == IDLE) ? req_addr : r_addr;
    assign w_dec_en   = (r_state == WR) || (r_state == SEL);

    regbus_decode #(
        .NrOfRegs (NrOfRegs),
        .AddrBits (AddrBits)
    ) u_decode (
        .addr         (w_dec_addr),
        .en           (w_dec_en),
        .onehot       (w_onehot),
        .out_of_range (w_oor)
    );

    // State register. An asynchronous reset drops cs/we at once, even mid-transfer.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the bus-facing outputs decoded from the state.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        cs          = '0;
        we          = '0;
        wr_data     = '0;
        case (r_state)
            IDLE: begin
                req_ready = Reset_n;
                if (req_valid) begin
                    if (w_oor)          w_state_nxt = RSP;
                    else if (req_write) w_state_nxt = WR;
                    else                w_state_nxt = SEL;
                end
            end
            WR: begin
                we      = w_onehot;
                wr_data = r_wdata;
                if (Tick) w_state_nxt = RSP;
            end
            SEL: begin
                cs = w_onehot;
                if (Tick && (r_cnt == '0)) w_state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, settle counter and response registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= c_cnt_init;
                        if (w_oor) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (Tick) begin
                        r_rsp_data <= r_wdata;
                        r_rsp_err  <= 1'b0;
                    end
                end
                SEL: begin
                    if (Tick) begin
                        if (r_cnt == '0) begin
                            r_rsp_data <= bus;
                            r_rsp_err  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_regbus_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbus_read_ctrl
//  Brief    : Testbench for regbus_read_ctrl. Uses directed vectors, the
//             reset and back-pressure corner cases, and random transactions.
//             Results are compared against a transaction-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbus_read_ctrl;

    localparam int NB = 32;
    localparam int NR = 6;
    localparam int AB = 3;
    localparam int SC = 2;

    logic          Clock     = 1'b0;
    logic          Reset_n   = 1'b0;
    logic          Tick      = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AB-1:0] req_addr  = '0;
    logic [NB-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [NB-1:0] rsp_data;
    logic          rsp_err;
    logic [NR-1:0] cs;
    logic [NR-1:0] we;
    logic [NB-1:0] wr_data;
    wire  [NB-1:0] bus;

    int checks = 0;
    int errors = 0;
    int tmode  = 1;      // 1: Tick every cycle, N>1: every Nth cycle, -1: random
    int cyc    = 0;
    logic bank_load = 1'b1;

    regbus_read_ctrl #(
        .NrOfBits     (NB),
        .NrOfRegs     (NR),
        .AddrBits     (AB),
        .SettleCycles (SC)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Tick      (Tick),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .cs        (cs),
        .we        (we),
        .wr_data   (wr_data),
        .bus       (bus)
    );

    initial forever #5 Clock = ~Clock;

    // Tick pattern, updated on the falling edge so it is stable at the rising edge
    initial forever begin
        @(negedge Clock);
        cyc++;
        if (tmode == -1)    Tick = 1'($urandom_range(0, 1));
        else if (tmode <= 1) Tick = 1'b1;
        else                Tick = ((cyc % tmode) == 0);
    end

    function automatic logic [NB-1:0] init_val(input int i);
        return (i == 5) ? 32'h1234_5678 : 32'h1000_0000 + NB'(i);
    endfunction

    // Environment register bank: captures on a Tick-qualified edge and drives the bus while selected
    logic [NB-1:0] bank [NR];
    logic [NB-1:0] bus_drv;
    always @(posedge Clock) begin
        for (int i = 0; i < NR; i++) begin
            if (bank_load)           bank[i] <= init_val(i);
            else if (we[i] && Tick)  bank[i] <= wr_data;
        end
    end
    // An unselected bus carries a poison value, so a capture at the wrong time shows up
    always_comb begin
        bus_drv = 32'hBAD0_0BAD;
        for (int i = 0; i < NR; i++) if (cs[i]) bus_drv = bank[i];
    end
    assign bus = bus_drv;

    // Reference model: architectural register contents, at transaction level
    logic [NB-1:0] mdl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariants that must hold every cycle
    always @(negedge Clock) begin
        if (Reset_n) begin
            chk("cs_onehot0", 64'($onehot0(cs)), 64'd1);
            chk("we_onehot0", 64'($onehot0(we)), 64'd1);
            chk("cs_we_excl", 64'((|cs) && (|we)), 64'd0);
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    // One full transaction. Records latency, Tick edges, cs/we activity and the response.
    task automatic run_txn(input bit wr, input logic [AB-1:0] addr, input logic [NB-1:0] wd,
                           output logic [NB-1:0] data, output logic err, output int lat,
                           output int tedges, output logic [NR-1:0] cs_seen,
                           output logic [NR-1:0] we_seen, output logic [NB-1:0] wd_seen);
        wait_ready();
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
        lat = 1; tedges = 0; cs_seen = '0; we_seen = '0; wd_seen = '0;
        while (!rsp_valid && lat < 200) begin
            cs_seen |= cs;
            we_seen |= we;
            if (we != '0) wd_seen = wr_data;
            step();
            lat++;
            tedges += int'(Tick);
        end
        chk("rsp_arrived", 64'(rsp_valid), 64'd1);
        chk("cswe_off_in_rsp", 64'({cs, we}), 64'd0);
        data = rsp_data;
        err  = rsp_err;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("back_to_idle", 64'(req_ready), 64'd1);
    endtask

    typedef struct {
        bit            wr;
        logic [AB-1:0] addr;
        logic [NB-1:0] wd;
        int            tm;
        logic [NB-1:0] exp_data;
        bit            exp_err;
        int            exp_lat;   // -1: latency not checked (Tick not continuous)
        logic [NR-1:0] exp_cs;
        logic [NR-1:0] exp_we;
    } vec_t;

    vec_t vecs [8];

    logic [NB-1:0] r_data, r_wd;
    logic          r_err;
    int            r_lat, r_ted;
    logic [NR-1:0] r_cs, r_we;

    // Compares one finished transaction against its expected outcome
    task automatic check_txn(input string tag, input bit wr, input logic [AB-1:0] addr,
                             input logic [NB-1:0] wd, input int exp_lat,
                             input logic [NB-1:0] exp_data, input bit exp_err,
                             input logic [NR-1:0] exp_cs, input logic [NR-1:0] exp_we);
        int exp_ted;
        exp_ted = exp_err ? 0 : (wr ? 1 : SC);
        chk({tag, "_data"},   64'(r_data), 64'(exp_data));
        chk({tag, "_err"},    64'(r_err),  64'(exp_err));
        chk({tag, "_tedges"}, 64'(r_ted),  64'(exp_ted));
        chk({tag, "_cs"},     64'(r_cs),   64'(exp_cs));
        chk({tag, "_we"},     64'(r_we),   64'(exp_we));
        if (exp_we != '0) chk({tag, "_wr_data"}, 64'(r_wd), 64'(wd));
        if (exp_lat >= 0) chk({tag, "_latency"}, 64'(r_lat), 64'(exp_lat));
        if (wr && !exp_err) mdl[addr] = wd;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mdl[i] = init_val(i);

        vecs[0] = '{1'b1, 3'd3, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0, 2,      6'b000000, 6'b001000};
        vecs[1] = '{1'b0, 3'd5, 32'h0,         1, 32'h1234_5678, 1'b0, SC+1,   6'b100000, 6'b000000};
        vecs[2] = '{1'b0, 3'd1, 32'h0,         4, 32'h1000_0001, 1'b0, -1,     6'b000010, 6'b000000};
        vecs[3] = '{1'b0, 3'd7, 32'h0,         1, 32'h0,         1'b1, 1,      6'b000000, 6'b000000};
        vecs[4] = '{1'b0, 3'd3, 32'h0,         1, 32'hDEAD_BEEF, 1'b0, SC+1,   6'b001000, 6'b000000};
        vecs[5] = '{1'b1, 3'd6, 32'h0000_AAAA, 1, 32'h0,         1'b1, 1,      6'b000000, 6'b000000};
        vecs[6] = '{1'b1, 3'd0, 32'h0000_55AA, 3, 32'h0000_55AA, 1'b0, -1,     6'b000000, 6'b000001};
        vecs[7] = '{1'b0, 3'd0, 32'h0,         2, 32'h0000_55AA, 1'b0, -1,     6'b000001, 6'b000000};

        // Reset state, while reset is held and just after release
        repeat (3) step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_cs",        64'(cs),        64'd0);
        chk("rst_we",        64'(we),        64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_wr_data",   64'(wr_data),   64'd0);
        @(negedge Clock);
        Reset_n   = 1'b1;
        bank_load = 1'b0;
        step();
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        chk("rel_cs_we",     64'({cs, we}),  64'd0);
        chk("rel_rsp_valid", 64'(rsp_valid), 64'd0);

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            tmode = vecs[v].tm;
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wd, r_data, r_err, r_lat, r_ted, r_cs, r_we, r_wd);
            check_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wd, vecs[v].exp_lat,
                      vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_cs, vecs[v].exp_we);
        end

        // Asynchronous reset while a read holds its chip-select
        tmode = 1;
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4;
        step();
        req_valid = 1'b0;
        chk("sel_cs_before_rst", 64'(cs), 64'(6'b010000));
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_cs",        64'(cs),        64'd0);
        chk("async_rst_req_ready", 64'(req_ready), 64'd0);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step();
        chk("post_rst_ready",    64'(req_ready), 64'd1);
        chk("post_rst_rsp_data", 64'(rsp_data),  64'd0);
        chk("post_rst_cs",       64'(cs),        64'd0);

        // Held response under back-pressure, with a second request waiting
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
        step();
        req_write = 1'b1; req_addr = 3'd4; req_wdata = 32'h0BAD_F00D;
        chk("busy_not_ready", 64'(req_ready), 64'd0);
        for (int n = 0; n < 50 && !rsp_valid; n++) step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rsp_data",  64'(rsp_data),  64'(mdl[2]));
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("hs_idle_ready",     64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk("next_accepted", 64'(req_ready), 64'd0);
        for (int n = 0; n < 50 && !rsp_valid; n++) step();
        chk("next_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("next_rsp_data",  64'(rsp_data),  64'h0BAD_F00D);
        chk("next_rsp_err",   64'(rsp_err),   64'd0);
        mdl[4] = 32'h0BAD_F00D;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Random traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            bit            wr;
            logic [AB-1:0] a;
            logic [NB-1:0] wd, ed;
            bit            ee;
            int            el;
            wr    = 1'($urandom_range(0, 1));
            a     = AB'($urandom_range(0, 7));
            wd    = NB'($urandom);
            tmode = ($urandom_range(0, 1) == 1) ? -1 : 1;
            ee    = (int'(a) >= NR);
            ed    = ee ? '0 : (wr ? wd : mdl[a]);
            el    = (tmode != 1) ? -1 : (ee ? 1 : (wr ? 2 : SC + 1));
            run_txn(wr, a, wd, r_data, r_err, r_lat, r_ted, r_cs, r_we, r_wd);
            check_txn($sformatf("rnd%0d", t), wr, a, wd, el, ed, ee,
                      (!ee && !wr) ? NR'(1 << a) : '0,
                      (!ee &&  wr) ? NR'(1 << a) : '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
